cpu_clk_sched: RTL and testbench

Clock-enable scheduler and run-control sequencer for the NES core, running entirely on `clk_ppu`. It derives the CPU cycle enable `cpu_ce` and the M2 enable `cpum2_ce` from the PPU clock at the NTSC (3:1) or PAL (16:5) ratio. It gates the whole PPU/CPU timebase for halt, run and N-cycle single-step debug control, and sequences CPU reset release. It sits between the clock generator and the PPU/CPU cores, replacing free-running gated CPU clocks with enables.

---
 rtl/cpu_clk_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_cpu_clk_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched
// Clock-enable scheduler and run-control sequencer for the NES core.
// Everything runs on clk_ppu. The CPU cycle enable (cpu_ce) and the M2
// enable (cpum2_ce) are derived from a small phase counter that advances
// only while the timebase is enabled (ppu_ce). A run-control FSM gates the
// timebase for halt / run / N-cycle step debug control, and a short
// sequencer holds the CPU in reset for a fixed number of CPU cycles after
// the scheduler leaves reset.
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.

module cpu_clk_sched #(
    parameter bit START_HALTED  = 1'b0,
    parameter int RST_CPU_DELAY = 2,
    parameter int STEP_W        = 16
) (
    input  logic              clk_ppu,
    input  logic              rst_ppu,
    input  logic              pal_mode,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    output logic              ppu_ce,
    output logic              cpum2_ce,
    output logic              cpu_ce,
    output logic              rst_cpu,
    output logic              halted,
    output logic [1:0]        state,
    output logic [31:0]       cpu_cycles
);

    // Run-control states; encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    localparam logic [STEP_W-1:0] REM_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] REM_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        RST_DLY  = 4'(RST_CPU_DELAY);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [1:0]          cnt_q,       cnt_d;       // phase within a CPU cycle
    logic [2:0]          pseq_q,      pseq_d;      // PAL cycle index 0..4
    logic                pal_q,       pal_d;       // mode of the current CPU cycle
    logic                halt_pend_q, halt_pend_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [3:0]          rst_cnt_q,   rst_cnt_d;
    logic                rst_cpu_q,   rst_cpu_d;
    logic [31:0]         cycles_q,    cycles_d;

    // Decoded timebase strobes
    logic ppu_ce_s;
    logic long_s;
    logic m2_hit_s;
    logic wrap_hit_s;
    logic cpum2_ce_s;
    logic cpu_ce_s;

    // Decode the enables from the registered state and phase.
    // A long (4-phase) CPU cycle is the 5th cycle of a PAL group.
    always_comb begin
        ppu_ce_s = (state_q == ST_RUN) || (state_q == ST_STEP);
        long_s   = pal_q && (pseq_q == 3'd4);
        if (long_s) begin
            m2_hit_s   = (cnt_q == 2'd2);
            wrap_hit_s = (cnt_q == 2'd3);
        end else begin
            m2_hit_s   = (cnt_q == 2'd1);
            wrap_hit_s = (cnt_q == 2'd2);
        end
        cpum2_ce_s = ppu_ce_s && m2_hit_s;
        cpu_ce_s   = ppu_ce_s && wrap_hit_s;
    end

    // Phase counter and PAL sequencing; the video mode is only picked up
    // at a CPU cycle boundary so a mode change never distorts a cycle.
    always_comb begin
        cnt_d  = cnt_q;
        pseq_d = pseq_q;
        pal_d  = pal_q;
        if (cpu_ce_s) begin
            cnt_d = 2'd0;
            pal_d = pal_mode;
            if (!pal_mode) begin
                pseq_d = 3'd0;
            end else if (!pal_q) begin
                // first PAL cycle after NTSC starts a fresh group
                pseq_d = 3'd0;
            end else if (pseq_q == 3'd4) begin
                pseq_d = 3'd0;
            end else begin
                pseq_d = pseq_q + 3'd1;
            end
        end else if (ppu_ce_s) begin
            cnt_d = cnt_q + 2'd1;
        end else begin
            // timebase frozen while halted or in reset state
            cnt_d = cnt_q;
        end
    end

    // Run-control FSM: next state, pending halt and step budget.
    // Halts are only taken on a cpu_ce cycle so a CPU cycle is never split.
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_RESET: begin
                halt_pend_d = 1'b0;
                remaining_d = REM_ZERO;
                if (START_HALTED) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_ce_s && (halt_pend_q || halt_req)) begin
                    state_d     = ST_HALT;
                    halt_pend_d = 1'b0;
                end else if (halt_req) begin
                    halt_pend_d = 1'b1;
                end else begin
                    halt_pend_d = halt_pend_q;
                end
            end
            ST_HALT: begin
                halt_pend_d = 1'b0;
                if (run_req) begin
                    state_d     = ST_RUN;
                    remaining_d = REM_ZERO;
                end else if (step_req && (step_count != REM_ZERO)) begin
                    state_d     = ST_STEP;
                    remaining_d = step_count;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (cpu_ce_s && (halt_pend_q || halt_req)) begin
                    state_d     = ST_HALT;
                    halt_pend_d = 1'b0;
                    remaining_d = REM_ZERO;
                end else if (run_req && !halt_req) begin
                    // run cancels the step budget; a halt in the same cycle wins
                    state_d     = ST_RUN;
                    remaining_d = REM_ZERO;
                end else if (cpu_ce_s && (remaining_q == REM_ONE)) begin
                    state_d     = ST_HALT;
                    remaining_d = REM_ZERO;
                end else if (cpu_ce_s) begin
                    remaining_d = remaining_q - REM_ONE;
                    halt_pend_d = halt_pend_q || halt_req;
                end else begin
                    halt_pend_d = halt_pend_q || halt_req;
                end
            end
            default: begin
                state_d     = ST_RESET;
                halt_pend_d = 1'b0;
                remaining_d = REM_ZERO;
            end
        endcase
    end

    // CPU reset release: count cpu_ce pulses while the CPU is held in reset.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        rst_cpu_d = rst_cpu_q;
        if (rst_cpu_q && cpu_ce_s) begin
            rst_cnt_d = rst_cnt_q + 4'd1;
            if (rst_cnt_d >= RST_DLY) begin
                rst_cpu_d = 1'b0;
            end else begin
                rst_cpu_d = 1'b1;
            end
        end else begin
            rst_cnt_d = rst_cnt_q;
        end
    end

    // Free-running CPU cycle counter, wraps at 2^32.
    always_comb begin
        if (cpu_ce_s) begin
            cycles_d = cycles_q + 32'd1;
        end else begin
            cycles_d = cycles_q;
        end
    end

    // State register with synchronous reset; reset discards any pending
    // halt or step work.
    always_ff @(posedge clk_ppu) begin
        if (rst_ppu) begin
            state_q     <= ST_RESET;
            cnt_q       <= 2'd0;
            pseq_q      <= 3'd0;
            pal_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            remaining_q <= REM_ZERO;
            rst_cnt_q   <= 4'd0;
            rst_cpu_q   <= 1'b1;
            cycles_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pseq_q      <= pseq_d;
            pal_q       <= pal_d;
            halt_pend_q <= halt_pend_d;
            remaining_q <= remaining_d;
            rst_cnt_q   <= rst_cnt_d;
            rst_cpu_q   <= rst_cpu_d;
            cycles_q    <= cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    assign ppu_ce     = ppu_ce_s;
    assign cpum2_ce   = cpum2_ce_s;
    assign cpu_ce     = cpu_ce_s;
    assign rst_cpu    = rst_cpu_q;
    assign halted     = (state_q == ST_HALT);
    assign state      = state_q;
    assign cpu_cycles = cycles_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// tb_cpu_clk_sched
// Directed bench for cpu_clk_sched. A cycle-level behavioural model of the
// scheduler runs alongside the DUT and is compared on every cycle; directed
// sequences add hand-computed expectations (pulse cycles, gap patterns,
// halt/step latencies, reset behaviour).

`timescale 1ns/1ps

module tb_cpu_clk_sched;

    localparam bit START_HALTED  = 1'b0;
    localparam int RST_CPU_DELAY = 2;
    localparam int STEP_W        = 16;

    logic              clk_ppu = 1'b0;
    logic              rst_ppu;
    logic              pal_mode;
    logic              run_req;
    logic              halt_req;
    logic              step_req;
    logic [STEP_W-1:0] step_count;
    logic              ppu_ce;
    logic              cpum2_ce;
    logic              cpu_ce;
    logic              rst_cpu;
    logic              halted;
    logic [1:0]        state;
    logic [31:0]       cpu_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit          m_valid = 1'b0;
    int          m_state;      // 0 RESET, 1 RUN, 2 HALT, 3 STEP
    int          m_elapsed;    // enabled PPU cycles spent in current CPU cycle
    bit          m_palcur;     // current CPU cycle is a PAL cycle
    int          m_palidx;     // position of current cycle in a 5-cycle PAL group
    bit          m_pend;
    int          m_rem;
    int          m_rpulses;
    bit          m_rstcpu;
    int unsigned m_cycles;

    cpu_clk_sched #(
        .START_HALTED (START_HALTED),
        .RST_CPU_DELAY(RST_CPU_DELAY),
        .STEP_W       (STEP_W)
    ) dut (
        .clk_ppu   (clk_ppu),
        .rst_ppu   (rst_ppu),
        .pal_mode  (pal_mode),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .step_count(step_count),
        .ppu_ce    (ppu_ce),
        .cpum2_ce  (cpum2_ce),
        .cpu_ce    (cpu_ce),
        .rst_cpu   (rst_cpu),
        .halted    (halted),
        .state     (state),
        .cpu_cycles(cpu_cycles)
    );

    always #5 clk_ppu = ~clk_ppu;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Length of a CPU cycle in PPU cycles: 16 PPU cycles carry 5 PAL CPU
    // cycles as 3+3+3+3+4; NTSC is always 3.
    function automatic int cycle_len(input bit pal, input int idx);
        if (pal && idx == 4) return 4;
        return 3;
    endfunction

    // Per-cycle comparison against the model, then advance the model with
    // the inputs that the next clock edge will see.
    task automatic compare_loop();
        int len;
        bit e_ppu, e_cpu, e_m2;
        int nstate;
        forever begin
            @(negedge clk_ppu);
            len   = cycle_len(m_palcur, m_palidx);
            e_ppu = (m_state == 1) || (m_state == 3);
            e_cpu = e_ppu && (m_elapsed == len - 1);
            e_m2  = e_ppu && (m_elapsed == len - 2);
            if (m_valid) begin
                check("mdl_ppu_ce",     64'(ppu_ce),     64'(e_ppu));
                check("mdl_cpu_ce",     64'(cpu_ce),     64'(e_cpu));
                check("mdl_cpum2_ce",   64'(cpum2_ce),   64'(e_m2));
                check("mdl_state",      64'(state),      64'(m_state));
                check("mdl_halted",     64'(halted),     64'(m_state == 2));
                check("mdl_rst_cpu",    64'(rst_cpu),    64'(m_rstcpu));
                check("mdl_cpu_cycles", 64'(cpu_cycles), 64'(m_cycles));
            end
            if (rst_ppu) begin
                m_state = 0; m_elapsed = 0; m_palcur = 1'b0; m_palidx = 0;
                m_pend = 1'b0; m_rem = 0; m_rpulses = 0; m_rstcpu = 1'b1;
                m_cycles = 0; m_valid = 1'b1;
            end else if (m_valid) begin
                if (e_cpu) begin
                    m_cycles++;
                    if (m_rstcpu) begin
                        m_rpulses++;
                        if (m_rpulses >= RST_CPU_DELAY) m_rstcpu = 1'b0;
                    end
                    m_elapsed = 0;
                    if (pal_mode) begin
                        m_palidx = m_palcur ? (m_palidx + 1) % 5 : 0;
                        m_palcur = 1'b1;
                    end else begin
                        m_palcur = 1'b0;
                        m_palidx = 0;
                    end
                end else if (e_ppu) begin
                    m_elapsed++;
                end
                nstate = m_state;
                case (m_state)
                    0: nstate = START_HALTED ? 2 : 1;
                    1: begin
                        if (e_cpu && (m_pend || halt_req)) begin nstate = 2; m_pend = 1'b0; end
                        else if (halt_req) m_pend = 1'b1;
                    end
                    2: begin
                        if (run_req) nstate = 1;
                        else if (step_req && step_count != 0) begin nstate = 3; m_rem = int'(step_count); end
                    end
                    3: begin
                        if (e_cpu && (m_pend || halt_req)) begin nstate = 2; m_pend = 1'b0; m_rem = 0; end
                        else if (run_req && !halt_req) begin nstate = 1; m_rem = 0; end
                        else begin
                            if (halt_req) m_pend = 1'b1;
                            if (e_cpu) begin
                                m_rem--;
                                if (m_rem == 0) nstate = 2;
                            end
                        end
                    end
                    default: nstate = 0;
                endcase
                m_state = nstate;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_ppu);
        #1;
    endtask

    // Count cycles (current one first) until cpu_ce; bounded.
    task automatic measure_gap(input string name, input int exp);
        int g;
        g = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_ppu);
            if (cpu_ce) begin g = k; break; end
        end
        check(name, 64'(g), 64'(exp));
    endtask

    // Entered with the current cycle being cycle 0 (first cycle out of reset).
    task automatic freerun_check(input string tag);
        int cpu_at[$];
        int m2_at[$];
        logic rc6, rc7;
        logic [31:0] cc31;
        rc6 = 1'b0; rc7 = 1'b1; cc31 = 32'd0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk_ppu);
            if (cpu_ce)   cpu_at.push_back(c);
            if (cpum2_ce) m2_at.push_back(c);
            if (c == 0) begin
                check({tag, "_c0_state"},    64'(state),      64'd0);
                check({tag, "_c0_ppu_ce"},   64'(ppu_ce),     64'd0);
                check({tag, "_c0_cpu_ce"},   64'(cpu_ce),     64'd0);
                check({tag, "_c0_rst_cpu"},  64'(rst_cpu),    64'd1);
                check({tag, "_c0_halted"},   64'(halted),     64'd0);
                check({tag, "_c0_cycles"},   64'(cpu_cycles), 64'd0);
            end
            if (c == 1) check({tag, "_c1_state"}, 64'(state), 64'd1);
            if (c == 6) rc6 = rst_cpu;
            if (c == 7) rc7 = rst_cpu;
            if (c == 31) cc31 = cpu_cycles;
        end
        check({tag, "_npulse"}, 64'(cpu_at.size()), 64'd10);
        if (cpu_at.size() >= 3 && m2_at.size() >= 3) begin
            check({tag, "_cpu0"}, 64'(cpu_at[0]), 64'd3);
            check({tag, "_cpu1"}, 64'(cpu_at[1]), 64'd6);
            check({tag, "_cpu2"}, 64'(cpu_at[2]), 64'd9);
            check({tag, "_m2_0"}, 64'(m2_at[0]),  64'd2);
            check({tag, "_m2_1"}, 64'(m2_at[1]),  64'd5);
            check({tag, "_m2_2"}, 64'(m2_at[2]),  64'd8);
        end else begin
            check({tag, "_enough_pulses"}, 64'(cpu_at.size()), 64'd10);
        end
        check({tag, "_rst_cpu_c6"}, 64'(rc6),  64'd1);
        check({tag, "_rst_cpu_c7"}, 64'(rc7),  64'd0);
        check({tag, "_cycles_c31"}, 64'(cc31), 64'd10);
    endtask

    initial begin
        int np, nc, prev, bad, first_m2;
        logic h2, h3, h6, h7;
        logic [1:0] s5;

        rst_ppu = 1'b1; pal_mode = 1'b0; run_req = 1'b0; halt_req = 1'b0;
        step_req = 1'b0; step_count = '0;
        fork
            compare_loop();
        join_none

        // reset state
        repeat (3) tick();
        @(negedge clk_ppu);
        check("rst_state",   64'(state),      64'd0);
        check("rst_rst_cpu", 64'(rst_cpu),    64'd1);
        check("rst_cycles",  64'(cpu_cycles), 64'd0);
        check("rst_ppu_ce",  64'(ppu_ce),     64'd0);

        // NTSC free run from reset
        tick(); rst_ppu = 1'b0;
        freerun_check("ntsc");

        // PAL: pick up mode at the next wrap, then 80 enabled cycles
        tick(); pal_mode = 1'b1;
        measure_gap("pal_entry_gap", 2);
        prev = 0; nc = 0; bad = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk_ppu);
            if (cpu_ce) begin
                if ((k - prev) != (((nc % 5) == 4) ? 4 : 3)) bad++;
                prev = k;
                nc++;
            end
        end
        check("pal_pulses_80", 64'(nc),   64'd25);
        check("pal_gap_errs",  64'(bad),  64'd0);
        check("pal_last_at",   64'(prev), 64'd80);

        // mode change in the middle of the long cycle applies only at its wrap
        for (int i = 0; i < 4; i++) measure_gap("pal_short_gap", 3);
        tick(); pal_mode = 1'b0;
        measure_gap("pal_long_kept", 4);
        measure_gap("ntsc_after_pal_a", 3);
        measure_gap("ntsc_after_pal_b", 3);

        // halt_req on the cycle right after a cpu_ce
        np = 0; nc = 0; h2 = 1'b1; h3 = 1'b0;
        tick(); halt_req = 1'b1;
        @(negedge clk_ppu); np += int'(ppu_ce); nc += int'(cpu_ce);
        tick(); halt_req = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_ppu);
            np += int'(ppu_ce); nc += int'(cpu_ce);
            if (k == 2) h2 = halted;
            if (k == 3) h3 = halted;
        end
        check("halt_ppu_cycles", 64'(np), 64'd3);
        check("halt_cpu_pulses", 64'(nc), 64'd1);
        check("halt_h2",         64'(h2), 64'd0);
        check("halt_h3",         64'(h3), 64'd1);

        // step 3 from HALT; resume starts at phase 0
        np = 0; nc = 0; first_m2 = -1;
        step_count = 16'd3;
        for (int k = 0; k < 15; k++) begin
            tick();
            step_req = (k == 0);
            @(negedge clk_ppu);
            np += int'(ppu_ce); nc += int'(cpu_ce);
            if (cpum2_ce && first_m2 < 0) first_m2 = k;
        end
        check("step3_ppu",      64'(np),       64'd9);
        check("step3_cpu",      64'(nc),       64'd3);
        check("step3_first_m2", 64'(first_m2), 64'd2);
        check("step3_halted",   64'(halted),   64'd1);

        // step with count 0 is ignored
        np = 0; step_count = 16'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            step_req = (k == 0);
            @(negedge clk_ppu);
            np += int'(ppu_ce);
        end
        check("step0_ppu",    64'(np),     64'd0);
        check("step0_halted", 64'(halted), 64'd1);

        // run_req and halt_req together during STEP: halt wins
        nc = 0; s5 = 2'd0; h6 = 1'b1; h7 = 1'b0; step_count = 16'd10;
        for (int k = 0; k < 16; k++) begin
            tick();
            step_req = (k == 0); run_req = (k == 4); halt_req = (k == 4);
            @(negedge clk_ppu);
            nc += int'(cpu_ce);
            if (k == 5) s5 = state;
            if (k == 6) h6 = halted;
            if (k == 7) h7 = halted;
        end
        check("stephr_cpu", 64'(nc), 64'd2);
        check("stephr_s5",  64'(s5), 64'd3);
        check("stephr_h6",  64'(h6), 64'd0);
        check("stephr_h7",  64'(h7), 64'd1);

        // run_req alone mid-STEP: continue in RUN
        nc = 0; s5 = 2'd0;
        for (int k = 0; k < 40; k++) begin
            tick();
            step_req = (k == 0); run_req = (k == 4); halt_req = 1'b0;
            @(negedge clk_ppu);
            nc += int'(cpu_ce);
            if (k == 5) s5 = state;
        end
        check("steprun_cpu",   64'(nc),    64'd13);
        check("steprun_s5",    64'(s5),    64'd1);
        check("steprun_state", 64'(state), 64'd1);

        // halt again, then reset in the middle of a step with 5 remaining
        for (int k = 0; k < 6; k++) begin
            tick();
            halt_req = (k == 0); run_req = 1'b0;
            @(negedge clk_ppu);
        end
        check("rehalt", 64'(halted), 64'd1);
        step_count = 16'd8;
        for (int k = 0; k <= 10; k++) begin
            tick();
            step_req = (k == 0); halt_req = 1'b0;
            rst_ppu = (k == 10);
            @(negedge clk_ppu);
            if (k == 10) check("midstep_state", 64'(state), 64'd3);
        end
        tick(); rst_ppu = 1'b0; step_req = 1'b0;
        freerun_check("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
